// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and constants for the FFT frame loader
package fft_pkg;

    localparam int DW    = 16;
    localparam int NPTS  = 4;
    localparam int PTR_W = $clog2(NPTS);

    // Real part sits in the upper half so a raw sample word casts directly.
    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        RUN,
        REL
    } ld_state_t;

endpackage

// File: rtl/fft_frame_loader_if.sv
// rtl/fft_frame_loader_if.sv - serial complex sample stream into the frame loader
interface fft_frame_loader_if #(
    parameter int DW = 16
);

    logic            s_valid;
    logic            s_ready;
    logic [2*DW-1:0] s_data;
    logic            s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );

endinterface

// File: rtl/fft_frame_bank.sv
// rtl/fft_frame_bank.sv - one frame buffer: NPTS complex points plus a full flag
module fft_frame_bank
    import fft_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   we,
    input  logic [PTR_W-1:0]       idx,
    input  cplx_t                  data,
    input  logic [PTR_W:0]         pad_from,
    input  logic                   set_full,
    input  logic                   clr_full,
    output cplx_t [NPTS-1:0]       pts,
    output logic                   full
);

    cplx_t [NPTS-1:0] pts_q, pts_d;
    logic             full_q, full_d;

    // Write one point; a short frame also clears every point above it so
    // stale data from the previous frame in this bank never reaches the core.
    always_comb begin
        pts_d  = pts_q;
        full_d = full_q;
        if (we) begin
            for (int i = 0; i < NPTS; i++) begin
                if (i == int'(idx)) begin
                    pts_d[i] = data;
                end else if ((i > int'(idx)) && (i >= int'(pad_from))) begin
                    pts_d[i] = '0;
                end
            end
        end
        if (set_full) begin
            full_d = 1'b1;
        end else if (clr_full) begin
            full_d = 1'b0;
        end
    end

    // Point storage and full flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pts_q  <= '0;
            full_q <= 1'b0;
        end else begin
            pts_q  <= pts_d;
            full_q <= full_d;
        end
    end

    assign pts  = pts_q;
    assign full = full_q;

endmodule

// File: rtl/fft_frame_loader.sv
// rtl/fft_frame_loader.sv - double-buffered 4-point frame packer and FFT core sequencer
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    fft_frame_loader_if.slave s_if,
    output logic              fft_clr,
    output logic              fft_en,
    output logic [2*DW-1:0]   in_point0,
    output logic [2*DW-1:0]   in_point1,
    output logic [2*DW-1:0]   in_point2,
    output logic [2*DW-1:0]   in_point3,
    input  logic              fft_done,
    output logic [15:0]       frame_cnt,
    output logic              timeout_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    ld_state_t         state_q, state_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              err_q, err_d;
    logic              alive_q, alive_d;

    logic              accept;
    logic              close;
    logic              rel;
    logic [PTR_W:0]    pad_from;
    cplx_t             smp;
    logic [1:0]        bank_full;
    cplx_t [NPTS-1:0]  bank_pts [2];
    cplx_t [NPTS-1:0]  view;

    // Ready is held low while in reset and for the first cycle after release.
    assign alive_d    = 1'b1;
    assign s_if.s_ready = alive_q && !bank_full[wr_bank_q];
    assign accept     = s_if.s_valid && s_if.s_ready;
    assign close      = accept && (s_if.s_last || (wr_ptr_q == PTR_W'(NPTS - 1)));
    assign pad_from   = s_if.s_last ? ({1'b0, wr_ptr_q} + 1'b1) : (PTR_W + 1)'(NPTS);
    assign smp        = s_if.s_data;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_frame_bank u_bank (
            .clk      (clk),
            .reset_n  (reset_n),
            .we       (accept && (wr_bank_q == 1'(b))),
            .idx      (wr_ptr_q),
            .data     (smp),
            .pad_from (pad_from),
            .set_full (close && (wr_bank_q == 1'(b))),
            .clr_full (rel && (rd_bank_q == 1'(b))),
            .pts      (bank_pts[b]),
            .full     (bank_full[b])
        );
    end

    // Fill pointer: advance per accepted sample, swap banks when a frame closes.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        wr_bank_d = wr_bank_q;
        if (accept) begin
            if (close) begin
                wr_ptr_d  = '0;
                wr_bank_d = ~wr_bank_q;
            end else begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end
    end

    // Launch sequencer: clear the core, run it until done or timeout, then free the bank.
    always_comb begin
        state_d     = state_q;
        rd_bank_d   = rd_bank_q;
        cnt_d       = cnt_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = err_q;
        rel         = 1'b0;
        case (state_q)
            IDLE: begin
                if (bank_full[rd_bank_q]) begin
                    state_d = CLR;
                end
            end
            CLR: begin
                frame_cnt_d = frame_cnt_q + 16'd1;
                cnt_d       = '0;
                state_d     = RUN;
            end
            RUN: begin
                if (fft_done) begin
                    state_d = REL;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = REL;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REL: begin
                rel       = 1'b1;
                rd_bank_d = ~rd_bank_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers for fill side and launch side.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
            alive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
            alive_q     <= alive_d;
        end
    end

    // The launched bank is full and therefore untouched by the fill side,
    // so its contents are stable from CLR through REL.
    assign view        = (state_q != IDLE) ? bank_pts[rd_bank_q] : '0;
    assign in_point0   = view[0];
    assign in_point1   = view[1];
    assign in_point2   = view[2];
    assign in_point3   = view[3];
    assign fft_clr     = (state_q == CLR);
    assign fft_en      = (state_q == RUN);
    assign frame_cnt   = frame_cnt_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// tb/tb_fft_frame_loader.sv - self-checking bench for fft_frame_loader
module tb_fft_frame_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        fft_done = 1'b0;
    logic        fft_clr, fft_en, timeout_err;
    logic [31:0] in_point0, in_point1, in_point2, in_point3;
    logic [15:0] frame_cnt;

    fft_frame_loader_if #(.DW(16)) sif ();

    fft_frame_loader #(.DW(16), .TIMEOUT(64)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_if        (sif),
        .fft_clr     (fft_clr),
        .fft_en      (fft_en),
        .in_point0   (in_point0),
        .in_point1   (in_point1),
        .in_point2   (in_point2),
        .in_point3   (in_point3),
        .fft_done    (fft_done),
        .frame_cnt   (frame_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int k);
        return {16'(k), 16'(1000 - k)};
    endfunction

    function automatic logic [127:0] frame4(input int k0);
        return {mk(k0 + 3), mk(k0 + 2), mk(k0 + 1), mk(k0)};
    endfunction

    // Core model: done after done_delay RUN cycles (never if <= 0).
    int   done_delay = 4;
    logic done_in_clr = 1'b0;
    int   run_cnt = 0;
    always @(negedge clk) begin
        if (fft_en) run_cnt++;
        else run_cnt = 0;
        fft_done = (fft_en && (done_delay > 0) && (run_cnt == done_delay)) || (done_in_clr && fft_clr);
    end

    // Launch monitor: capture frames at CLR, check they hold through RUN.
    logic [127:0] launch_q [$];
    int           clr_cyc [$];
    int           run_lens [$];
    int           clr_count = 0;
    int           en_len = 0;
    logic         en_prev = 1'b0;
    always @(negedge clk) begin
        if (fft_clr) begin
            launch_q.push_back({in_point3, in_point2, in_point1, in_point0});
            clr_cyc.push_back(cyc);
            clr_count++;
        end
        if (fft_en) begin
            en_len++;
            if (launch_q.size() > 0)
                check("run_hold", {in_point3, in_point2, in_point1, in_point0}, launch_q[launch_q.size() - 1]);
        end else if (en_prev) begin
            run_lens.push_back(en_len);
            en_len = 0;
        end
        en_prev = fft_en;
    end

    int last_acc = 0;
    int acc_log [$];

    task automatic send(input logic [31:0] d, input logic last);
        int t;
        t = 0;
        sif.s_valid = 1'b1;
        sif.s_data  = d;
        sif.s_last  = last;
        while (!sif.s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("send_timeout", 128'(t), 128'd0);
        last_acc = cyc;
        acc_log.push_back(cyc);
        @(negedge clk);
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
    endtask

    task automatic wait_launch(input int n);
        int t;
        t = 0;
        while (run_lens.size() < n && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) check("wait_launch", 128'(run_lens.size()), 128'(n));
        @(negedge clk);
    endtask

    typedef struct {
        int               n;
        logic             last;
        int               dly;
        logic [3:0][31:0] smp;
        logic [127:0]     exp_pts;
        logic [15:0]      exp_fc;
    } vec_t;

    vec_t vt [5];
    int   base;
    int   ai;
    int   t;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{4, 1'b0, 4, {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000},
                  {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0001_0000}, 16'd1};
        vt[1] = '{3, 1'b1, 1, {32'hDEAD_BEEF, 32'h0007_0000, 32'h0006_0000, 32'h0005_0000},
                  {32'h0000_0000, 32'h0007_0000, 32'h0006_0000, 32'h0005_0000}, 16'd2};
        vt[2] = '{1, 1'b1, 2, {32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hFFFF_0009},
                  {32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_0009}, 16'd3};
        vt[3] = '{4, 1'b1, 8, {32'h0007_0007, 32'h0000_0001, 32'h0064_FF9C, 32'h8000_7FFF},
                  {32'h0007_0007, 32'h0000_0001, 32'h0064_FF9C, 32'h8000_7FFF}, 16'd4};
        vt[4] = '{2, 1'b1, 3, {32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hAAAA_5555, 32'h1234_5678},
                  {32'h0000_0000, 32'h0000_0000, 32'hAAAA_5555, 32'h1234_5678}, 16'd5};

        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        sif.s_last  = 1'b0;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_s_ready", 128'(sif.s_ready), 128'd0);
        check("rst_fft_clr", 128'(fft_clr), 128'd0);
        check("rst_fft_en", 128'(fft_en), 128'd0);
        check("rst_frame_cnt", 128'(frame_cnt), 128'd0);
        check("rst_timeout_err", 128'(timeout_err), 128'd0);
        check("rst_in_points", {in_point3, in_point2, in_point1, in_point0}, 128'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 128'(sif.s_ready), 128'd1);

        // Directed frames: full, short, single-sample, s_last on 4th, two-sample.
        for (int v = 0; v < 5; v++) begin
            done_delay = vt[v].dly;
            base = clr_count;
            for (int i = 0; i < vt[v].n; i++)
                send(vt[v].smp[i], vt[v].last && (i == vt[v].n - 1));
            wait_launch(base + 1);
            check($sformatf("v%0d_points", v), launch_q[base], vt[v].exp_pts);
            check($sformatf("v%0d_latency", v), 128'(clr_cyc[base] - last_acc), 128'd2);
            check($sformatf("v%0d_run_len", v), 128'(run_lens[base]), 128'(vt[v].dly));
            check($sformatf("v%0d_frame_cnt", v), 128'(frame_cnt), 128'(vt[v].exp_fc));
            check($sformatf("v%0d_no_err", v), 128'(timeout_err), 128'd0);
        end

        // Back-to-back: B's last sample lands in the same cycle REL frees A.
        done_delay = 1;
        base = clr_count;
        ai = acc_log.size();
        for (int k = 1; k <= 12; k++) send(mk(k), 1'b0);
        wait_launch(base + 3);
        check("b2b_no_stall", 128'(acc_log[ai + 11] - acc_log[ai]), 128'd11);
        check("b2b_rel_coincide", 128'(acc_log[ai + 7]), 128'(clr_cyc[base] + 2));
        check("b2b_frame_a", launch_q[base], frame4(1));
        check("b2b_frame_b", launch_q[base + 1], frame4(5));
        check("b2b_frame_c", launch_q[base + 2], frame4(9));
        check("b2b_frame_cnt", 128'(frame_cnt), 128'd8);

        // fft_done pulsed during CLR must not cut the run short.
        done_in_clr = 1'b1;
        done_delay = 3;
        base = clr_count;
        for (int k = 71; k <= 74; k++) send(mk(k), 1'b0);
        wait_launch(base + 1);
        done_in_clr = 1'b0;
        check("clr_done_run_len", 128'(run_lens[base]), 128'd3);
        check("clr_done_points", launch_q[base], frame4(71));

        // Done arriving on the timeout cycle wins.
        done_delay = 64;
        base = clr_count;
        for (int k = 81; k <= 84; k++) send(mk(k), 1'b0);
        wait_launch(base + 1);
        check("tie_run_len", 128'(run_lens[base]), 128'd64);
        check("tie_no_err", 128'(timeout_err), 128'd0);
        check("tie_frame_cnt", 128'(frame_cnt), 128'd10);

        // Core never finishes: both banks fill, ready drops, timeouts release in order.
        done_delay = -1;
        base = clr_count;
        for (int k = 21; k <= 28; k++) send(mk(k), 1'b0);
        check("to_ready_low", 128'(sif.s_ready), 128'd0);
        send(mk(29), 1'b0);
        check("to_ready_rise", 128'(last_acc), 128'(clr_cyc[base] + 66));
        check("to_err_set", 128'(timeout_err), 128'd1);
        check("to_run_len", 128'(run_lens[base]), 128'd64);
        for (int k = 30; k <= 32; k++) send(mk(k), 1'b0);
        wait_launch(base + 3);
        check("to_frame_a", launch_q[base], frame4(21));
        check("to_frame_b", launch_q[base + 1], frame4(25));
        check("to_frame_c", launch_q[base + 2], frame4(29));
        check("to_frame_cnt", 128'(frame_cnt), 128'd13);
        check("to_err_sticky", 128'(timeout_err), 128'd1);

        // Reset mid-RUN with a partial frame pending.
        base = clr_count;
        for (int k = 41; k <= 44; k++) send(mk(k), 1'b0);
        t = 0;
        while (!fft_en && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("mr_in_run", 128'(fft_en), 128'd1);
        send(mk(45), 1'b0);
        send(mk(46), 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("mr_fft_en", 128'(fft_en), 128'd0);
        check("mr_frame_cnt", 128'(frame_cnt), 128'd0);
        check("mr_timeout_err", 128'(timeout_err), 128'd0);
        check("mr_s_ready", 128'(sif.s_ready), 128'd0);
        check("mr_in_points", {in_point3, in_point2, in_point1, in_point0}, 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        done_delay = 4;
        base = clr_count;
        for (int k = 51; k <= 54; k++) send(mk(k), 1'b0);
        wait_launch(base + 1);
        check("mr_new_frame", launch_q[base], frame4(51));
        check("mr_new_frame_cnt", 128'(frame_cnt), 128'd1);

        // frame_cnt wrap.
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        @(negedge clk);
        check("wrap_preset", 128'(frame_cnt), 128'hFFFF);
        done_delay = 2;
        base = clr_count;
        for (int k = 61; k <= 64; k++) send(mk(k), 1'b0);
        wait_launch(base + 1);
        check("wrap_frame_cnt", 128'(frame_cnt), 128'd0);
        check("wrap_points", launch_q[base], frame4(61));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
